fp2fix: RTL and testbench
=========================

# fp2fix

Multi-cycle converter from IEEE-754 single-precision to signed fixed-point with saturation. It sits directly downstream of the `fpadd` mixer stage and takes the float sum when that stage raises `done`. It hands a two's-complement sample (default Q1.15) to the DAC/codec output path. Latency is fixed at 4 cycles, with a start/done handshake.

## Interface
- `OUT_WIDTH`, 16: output width in bits; legal range 8..24.
- `FRAC_BITS`, 15: fractional bits of the output; legal range 0..`OUT_WIDTH`-1.
- `clk`  in  1  sole clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  request a conversion; honoured only when not `busy`.
- `dataa`  in  32  IEEE single input; sampled on the accepting edge.
- `result`  out  `OUT_WIDTH`  signed fixed-point output; valid while `done`=1.
- `clipped`  out  1  output was saturated; valid while `done`=1.
- `busy`  out  1  conversion in progress.
- `done`  out  1  level; high from conversion end until the next accepted `start`.

## Operation
- FSM states and transitions:
  - IDLE → UNPACK on `start`.
  - UNPACK → SHIFT → ROUND → IDLE, unconditionally.
  - `busy` = (state ≠ IDLE).
- Accept (IDLE and `start`): latch `dataa`; clear `done` and `clipped`.
- `start` while `busy` is ignored; the latched input is unaffected.
- UNPACK decodes sign s, exponent e, and mant24 = {1, m[22:0]}.
  - Unbiased exponent k = e − `EXP_BIAS` (signed, 10 bits).
  - Right-shift amount r = 23 − (k + `FRAC_BITS`).
  - Output-range rules guarantee r ≥ 1 whenever no saturation occurs, so a left shift is never needed.
- Classification in UNPACK, in priority order:
  - e = 255 with m ≠ 0 (NaN): result 0, clipped 0.
  - e = 255 with m = 0 (±inf): saturate by sign, clipped 1.
  - e = 0 (zero or denormal): result 0, clipped 0.
  - k + `FRAC_BITS` ≥ `OUT_WIDTH` − 1: saturate by sign.
    - clipped = 1, except the exact value −2^(`OUT_WIDTH`−1) (s = 1, m = 0, k + `FRAC_BITS` = `OUT_WIDTH` − 1), which gives clipped 0.
  - r > 31: magnitude 0.
  - Otherwise: normal path.
- Saturation values: positive → 2^(`OUT_WIDTH`−1) − 1; negative → −2^(`OUT_WIDTH`−1).
- SHIFT: the shifter applies a logical right shift to {8'b0, mant24} by r (by r − 1 when rounding is enabled). The shifter output is registered.
- ROUND:
  - Apply rounding if configured.
  - If magnitude ≥ 2^(`OUT_WIDTH`−1): positive saturates with clipped 1; negative with magnitude exactly 2^(`OUT_WIDTH`−1) is the exact minimum, clipped 0.
  - Negate if s = 1.
  - Write `result`, set `done`.
- Negative zero after rounding gives result 0.

## Timing
- `start` sampled high at edge E0: `busy`=1 after E0, `done`=0 after E0.
- Edge E3: `result` and `clipped` updated, `done`=1, `busy`=0.
- Latency is 4 cycles for every input, including special cases, which still traverse all states.
- Back-to-back: `start` held high at E3 is not accepted (still `busy`). The earliest next accept is E4, so throughput is one conversion per 4 cycles.
- `result` and `clipped` hold their values until the ROUND edge of the next conversion.
- Reset values: `result`=0, `clipped`=0, `busy`=0, `done`=0, state IDLE.
- Reset asserted mid-conversion aborts it immediately; no `done` is produced.

## Configuration
- `FP2FIX_ROUND_EN` defined:
  - Shift by r − 1, keeping one guard bit.
  - Add the guard bit to the magnitude, then drop it.
  - Net effect: round half away from zero; rounding overflow saturates (clipped 1).
  - When r − 1 > 31 the magnitude is 0.
- Undefined: truncate the magnitude (round toward zero); no rounding overflow is possible.

## Structure
- Shared package `dsp_pkg` holds:
  - `EXP_BIAS`=127 and `EXP_SPECIAL`=255.
  - The mantissa width constant (23).
  - The fp2fix state enum.
- Sub-module: reuse the existing 32-bit `barrel_shift` for the SHIFT stage (logical, right).
  - Its inputs are registered in UNPACK.
  - Its output is captured in SHIFT.

## Test plan
- 0x3F000000 (0.5), defaults → `result`=0x4000, clipped 0, `done` 4 cycles after `start`.
- 0xBF800000 (−1.0) → 0x8000, clipped 0. 0x40000000 (2.0) → 0x7FFF, clipped 1.
- 0x38400000 (1.5 LSB): with `FP2FIX_ROUND_EN` → 0x0002; without → 0x0001.
- 0x3F7FFFFF: with round → 0x7FFF, clipped 1; without → 0x7FFF, clipped 0.
- 0x7FC00000 (NaN) → 0, clipped 0. 0xFF800000 (−inf) → 0x8000, clipped 1. 0x00000001 (denormal) → 0.
- Control sequencing:
  - `start` pulsed at E1 and E2 after an accept at E0: ignored, one `done` at E3.
  - `reset` at E2: all outputs 0, and no `done` follows.

Source files
------------

// File: rtl/dsp_pkg.sv
// Shared DSP constants and enums: IEEE single fields and fp2fix state/classes.
package dsp_pkg;
  localparam int EXP_BIAS    = 127;
  localparam int EXP_SPECIAL = 255;
  localparam int MANT_W      = 23;

  typedef enum logic [1:0] {
    FP_IDLE   = 2'd0,
    FP_UNPACK = 2'd1,
    FP_SHIFT  = 2'd2,
    FP_ROUND  = 2'd3
  } fp2fix_state_t;

  typedef enum logic [1:0] {
    CLS_NORM = 2'd0,
    CLS_ZERO = 2'd1,
    CLS_SAT  = 2'd2
  } fp2fix_cls_t;
endpackage

// File: rtl/barrel_shift.sv
// 32-bit combinational barrel shifter: logical/arithmetic right or logical left.
module barrel_shift (
  input  logic [31:0] i_data,
  input  logic [4:0]  i_amt,
  input  logic        i_left,
  input  logic        i_arith,
  output logic [31:0] o_data
);
  always_comb begin
    o_data = i_data >> i_amt;
    if (i_left)
      o_data = i_data << i_amt;
    else if (i_arith)
      o_data = $unsigned($signed(i_data) >>> i_amt);
  end
endmodule

// File: rtl/fp2fix.sv
// IEEE-754 single to saturating signed fixed point, fixed 4-cycle latency.
// Define FP2FIX_ROUND_EN for round-half-away-from-zero; default truncates.
module fp2fix
  import dsp_pkg::*;
#(
  parameter int OUT_WIDTH = 16,
  parameter int FRAC_BITS = 15
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [31:0]          dataa,
  output logic [OUT_WIDTH-1:0] result,
  output logic                 clipped,
  output logic                 busy,
  output logic                 done,
  output logic [1:0]           o_dbg_state
);
`ifdef FP2FIX_ROUND_EN
  localparam int ROUND_SH = 1;
`else
  localparam int ROUND_SH = 0;
`endif
  localparam logic [OUT_WIDTH-1:0] SAT_POS = {1'b0, {(OUT_WIDTH-1){1'b1}}};
  localparam logic [OUT_WIDTH-1:0] SAT_NEG = {1'b1, {(OUT_WIDTH-1){1'b0}}};
  localparam logic [32:0]          MAG_LIM = 33'd1 << (OUT_WIDTH-1);

  // Handshake: start is accepted only in IDLE; done is a level that rises at
  // the ROUND edge and falls at the next accepted start.
  fp2fix_state_t         r_state, w_next;
  fp2fix_cls_t           r_cls, w_cls;
  logic [31:0]           r_dataa, r_bs_data, r_shifted, w_bs_out;
  logic [4:0]            r_bs_amt;
  logic                  r_sign, r_sat_clip, w_sat_clip, w_clip;
  logic [7:0]            w_exp;
  logic [22:0]           w_man;
  logic [32:0]           w_mag;
  logic [OUT_WIDTH-1:0]  w_result;
  int                    w_kf, w_sh;

  assign w_exp       = r_dataa[30:23];
  assign w_man       = r_dataa[22:0];
  assign w_kf        = int'(w_exp) - EXP_BIAS + FRAC_BITS;
  assign w_sh        = MANT_W - w_kf - ROUND_SH;
  assign busy        = (r_state != FP_IDLE);
  assign o_dbg_state = r_state;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= FP_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      FP_IDLE:   if (start) w_next = FP_UNPACK;
      FP_UNPACK: w_next = FP_SHIFT;
      FP_SHIFT:  w_next = FP_ROUND;
      FP_ROUND:  w_next = FP_IDLE;
      default:   w_next = FP_IDLE;
    endcase
  end

  // Classification priority: NaN, inf, zero/denormal, overrange, underrange.
  always_comb begin
    w_cls      = CLS_NORM;
    w_sat_clip = 1'b0;
    if (int'(w_exp) == EXP_SPECIAL && w_man != '0) begin
      w_cls = CLS_ZERO;
    end else if (int'(w_exp) == EXP_SPECIAL) begin
      w_cls      = CLS_SAT;
      w_sat_clip = 1'b1;
    end else if (w_exp == 8'd0) begin
      w_cls = CLS_ZERO;
    end else if (w_kf >= OUT_WIDTH-1) begin
      w_cls      = CLS_SAT;
      w_sat_clip = !(r_dataa[31] && w_man == '0 && w_kf == OUT_WIDTH-1);
    end else if (w_sh > 31) begin
      w_cls = CLS_ZERO;
    end
  end

  barrel_shift u_shift (
    .i_data  (r_bs_data),
    .i_amt   (r_bs_amt),
    .i_left  (1'b0),
    .i_arith (1'b0),
    .o_data  (w_bs_out)
  );

`ifdef FP2FIX_ROUND_EN
  assign w_mag = {2'b00, r_shifted[31:1]} + {32'd0, r_shifted[0]};
`else
  assign w_mag = {1'b0, r_shifted};
`endif

  always_comb begin
    w_result = '0;
    w_clip   = 1'b0;
    case (r_cls)
      CLS_ZERO: ;
      CLS_SAT: begin
        w_result = r_sign ? SAT_NEG : SAT_POS;
        w_clip   = r_sat_clip;
      end
      default: begin
        if (w_mag >= MAG_LIM) begin
          // A negative magnitude of exactly 2^(W-1) is representable.
          w_result = r_sign ? SAT_NEG : SAT_POS;
          w_clip   = !(r_sign && w_mag == MAG_LIM);
        end else begin
          w_result = r_sign ? -w_mag[OUT_WIDTH-1:0] : w_mag[OUT_WIDTH-1:0];
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_dataa    <= '0;
      r_sign     <= 1'b0;
      r_cls      <= CLS_ZERO;
      r_sat_clip <= 1'b0;
      r_bs_data  <= '0;
      r_bs_amt   <= '0;
      r_shifted  <= '0;
      result     <= '0;
      clipped    <= 1'b0;
      done       <= 1'b0;
    end else begin
      case (r_state)
        FP_IDLE: if (start) begin
          r_dataa <= dataa;
          done    <= 1'b0;
          clipped <= 1'b0;
        end
        FP_UNPACK: begin
          r_sign     <= r_dataa[31];
          r_cls      <= w_cls;
          r_sat_clip <= w_sat_clip;
          r_bs_data  <= {8'd0, 1'b1, w_man};
          r_bs_amt   <= w_sh[4:0];
        end
        FP_SHIFT: r_shifted <= w_bs_out;
        FP_ROUND: begin
          result  <= w_result;
          clipped <= w_clip;
          done    <= 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_fp2fix.sv
// Self-checking bench for fp2fix: vector table, control corner cases, random vs model.
module tb_fp2fix;
  localparam int OW = 16;
  localparam int FB = 15;
`ifdef FP2FIX_ROUND_EN
  localparam bit RND = 1'b1;
`else
  localparam bit RND = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset, start;
  logic [31:0]   dataa;
  logic [OW-1:0] result;
  logic          clipped, busy, done;
  logic [1:0]    dbg_state;

  int n_checks = 0;
  int n_fail   = 0;
  logic [OW:0] exp_q[$];

  typedef struct {
    logic [31:0]   a;
    logic [OW-1:0] res_t;
    logic          clip_t;
    logic [OW-1:0] res_r;
    logic          clip_r;
  } vec_t;
  vec_t tbl[12];

  always #5 clk = ~clk;

  fp2fix #(.OUT_WIDTH(OW), .FRAC_BITS(FB)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .dataa       (dataa),
    .result      (result),
    .clipped     (clipped),
    .busy        (busy),
    .done        (done),
    .o_dbg_state (dbg_state)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp_v);
    end
  endtask

  // Value-level reference: x = (-1)^s * mant24 * 2^(e-127-23), scaled by 2^FB.
  function automatic logic [OW:0] model(input logic [31:0] a);
    int e, kf, sh;
    logic s;
    logic [22:0] m;
    longint unsigned mant, mag, half, lim;
    logic [OW-1:0] maxv, minv, val;
    s = a[31];
    e = int'(a[30:23]);
    m = a[22:0];
    maxv = '1; maxv[OW-1] = 1'b0;
    minv = '0; minv[OW-1] = 1'b1;
    lim = 64'd1 << (OW-1);
    if (e == 255 && m != 0) return '0;
    if (e == 255) return {1'b1, s ? minv : maxv};
    if (e == 0) return '0;
    kf = e - 127 + FB;
    if (kf >= OW-1) return {!(s && m == 0 && kf == OW-1), s ? minv : maxv};
    sh = 23 - kf;
    mant = (64'd1 << 23) | 64'(m);
    if (RND) begin
      half = (sh <= 64) ? (64'd1 << (sh-1)) : 64'd0;
      mag = (mant + half) >> sh;
    end else begin
      mag = mant >> sh;
    end
    if (mag >= lim) begin
      if (s && mag == lim) return {1'b0, minv};
      return {1'b1, s ? minv : maxv};
    end
    val = mag[OW-1:0];
    if (s) val = -val;
    return {1'b0, val};
  endfunction

  task automatic convert(input logic [31:0] a, output logic [OW-1:0] res,
                         output logic clp, output int lat);
    @(negedge clk);
    dataa = a;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    dataa = $urandom;
    check("busy_after_accept", 32'(busy), 32'd1);
    check("done_cleared", 32'(done), 32'd0);
    lat = 0;
    while (!done && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("busy_at_done", 32'(busy), 32'd0);
    res = result;
    clp = clipped;
  endtask

  task automatic run_and_score(input string name, input logic [31:0] a);
    logic [OW-1:0] res;
    logic clp;
    int lat;
    logic [OW:0] exp_v;
    convert(a, res, clp, lat);
    check({name, "_latency"}, 32'(lat), 32'd3);
    if (exp_q.size() == 0) begin
      check({name, "_queue_empty"}, 32'd1, 32'd0);
    end else begin
      exp_v = exp_q.pop_front();
      check(name, 32'({clp, res}), 32'(exp_v));
    end
  endtask

  initial begin
    logic [OW:0] ev;
    logic [31:0] a;
    bit saw_done;

    tbl[0]  = '{32'h3F000000, 16'h4000, 1'b0, 16'h4000, 1'b0};
    tbl[1]  = '{32'hBF800000, 16'h8000, 1'b0, 16'h8000, 1'b0};
    tbl[2]  = '{32'h40000000, 16'h7FFF, 1'b1, 16'h7FFF, 1'b1};
    tbl[3]  = '{32'h38400000, 16'h0001, 1'b0, 16'h0002, 1'b0};
    tbl[4]  = '{32'h3F7FFFFF, 16'h7FFF, 1'b0, 16'h7FFF, 1'b1};
    tbl[5]  = '{32'h7FC00000, 16'h0000, 1'b0, 16'h0000, 1'b0};
    tbl[6]  = '{32'hFF800000, 16'h8000, 1'b1, 16'h8000, 1'b1};
    tbl[7]  = '{32'h00000001, 16'h0000, 1'b0, 16'h0000, 1'b0};
    tbl[8]  = '{32'hBF000000, 16'hC000, 1'b0, 16'hC000, 1'b0};
    tbl[9]  = '{32'hB8000000, 16'hFFFF, 1'b0, 16'hFFFF, 1'b0};
    tbl[10] = '{32'hB7800000, 16'h0000, 1'b0, 16'hFFFF, 1'b0};
    tbl[11] = '{32'hC0000000, 16'h8000, 1'b1, 16'h8000, 1'b1};

    reset = 1'b1;
    start = 1'b0;
    dataa = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_result", 32'(result), 32'd0);
    check("reset_clipped", 32'(clipped), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_state", 32'(dbg_state), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 12; i++) begin
      ev = RND ? {tbl[i].clip_r, tbl[i].res_r} : {tbl[i].clip_t, tbl[i].res_t};
      exp_q.push_back(ev);
      run_and_score($sformatf("table_%0d", i), tbl[i].a);
    end

    // start pulsed during E1/E2 is ignored; one done at E3 for the first input
    @(negedge clk);
    dataa = 32'h3F000000;
    start = 1'b1;
    @(posedge clk);
    #1;
    dataa = 32'h40000000;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    #1;
    check("ignore_done", 32'(done), 32'd1);
    check("ignore_result", 32'(result), 32'h4000);
    check("ignore_clipped", 32'(clipped), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("ignore_no_reaccept", 32'({busy, done}), 32'b01);
    end

    // start held high: E3 not accepted, E4 accepted, result held until next ROUND
    @(negedge clk);
    dataa = 32'hBF000000;
    start = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("b2b_done_e3", 32'({busy, done}), 32'b01);
    check("b2b_result_e3", 32'(result), 32'hC000);
    dataa = 32'h3F000000;
    @(posedge clk);
    #1;
    check("b2b_accept_e4", 32'({busy, done}), 32'b10);
    check("b2b_hold_result", 32'(result), 32'hC000);
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("b2b_hold_result_late", 32'(result), 32'hC000);
    @(posedge clk);
    #1;
    check("b2b_second_done", 32'(done), 32'd1);
    check("b2b_second_result", 32'(result), 32'h4000);

    // reset during conversion aborts it with no done
    @(negedge clk);
    dataa = 32'h40000000;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("abort_outputs", 32'({result, clipped, busy, done}), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    saw_done = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      if (done || busy) saw_done = 1'b1;
    end
    check("abort_no_done", 32'(saw_done), 32'd0);

    for (int i = 0; i < 300; i++) begin
      a = $urandom;
      if ($urandom_range(0, 3) != 0) a[30:23] = 8'($urandom_range(100, 145));
      exp_q.push_back(model(a));
      run_and_score("random", a);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
